// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // RISC-V M-extension Funct3 encodings.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StIter = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic signed_a(muldiv_op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM.
  function automatic logic signed_b(muldiv_op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation, purely combinational.
module cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // Pass through, or invert-and-increment when negation is requested.
  always_comb begin
    val_o = val_i;
    if (neg_i) begin
      val_o = ~val_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring-divide unit for RV32M/RV64M.
// Fixed latency: PREP, XLEN ITER cycles, FIX, then a one-cycle DONE.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            Kill,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  // Multiply: multiplicand. Divide: divisor.
  logic [XLEN-1:0]   mag_q, mag_d;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic accept;
  logic mul_mode;
  logic neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && Start && !Kill;
  assign mul_mode = !is_div(op_q);
  assign neg_a    = signed_a(op_q) & a_q[XLEN-1];
  assign neg_b    = signed_b(op_q) & b_q[XLEN-1];

  cond_negate #(
    .WIDTH (XLEN)
  ) u_abs_a (
    .val_i (a_q),
    .neg_i (neg_a),
    .val_o (abs_a)
  );

  cond_negate #(
    .WIDTH (XLEN)
  ) u_abs_b (
    .val_i (b_q),
    .neg_i (neg_b),
    .val_o (abs_b)
  );

  // Shared iteration adder. The extra top bit is the borrow for the divide trial subtract.
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] add_x, add_y, add_sum;
  logic            add_cin;
  logic            trial_ok;
  logic [2*XLEN-1:0] iter_acc;

  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];
  assign rem_sh = acc_q[2*XLEN-1:XLEN-1];

  // Select adder operands: accumulate for multiply, trial-subtract for divide.
  always_comb begin
    add_x   = {2'b00, acc_hi};
    add_y   = '0;
    add_cin = 1'b0;
    if (mul_mode) begin
      if (acc_q[0]) begin
        add_y = {2'b00, mag_q};
      end
    end else begin
      add_x   = {1'b0, rem_sh};
      add_y   = ~{2'b00, mag_q};
      add_cin = 1'b1;
    end
  end

  assign add_sum  = add_x + add_y + {{(XLEN + 1){1'b0}}, add_cin};
  assign trial_ok = !add_sum[XLEN+1];

  // One radix-2 step of shift-add multiply or restoring divide.
  always_comb begin
    if (mul_mode) begin
      iter_acc = {add_sum[XLEN:0], acc_lo[XLEN-1:1]};
    end else if (trial_ok) begin
      iter_acc = {add_sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
    end else begin
      iter_acc = {rem_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    end
  end

  // Final sign fixup on the full product, or on the zero-extended quotient/remainder.
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic              div_by_zero;
  logic [XLEN-1:0]   fix_result;

  assign div_by_zero = (b_q == '0);

  // Choose which value gets sign-corrected and whether to negate it.
  always_comb begin
    fix_in  = acc_q;
    fix_neg = sign_a_q ^ sign_b_q;
    if (!mul_mode) begin
      if (op_q[1]) begin
        fix_in  = {{XLEN{1'b0}}, acc_hi};
        fix_neg = sign_a_q;
      end else begin
        fix_in  = {{XLEN{1'b0}}, acc_lo};
      end
    end
  end

  cond_negate #(
    .WIDTH (2 * XLEN)
  ) u_fix (
    .val_i (fix_in),
    .neg_i (fix_neg),
    .val_o (fix_out)
  );

  // Pick the architectural result. MIN / -1 needs no special case: |MIN| / 1 gives
  // MIN with remainder 0, and both signs set means no negation.
  always_comb begin
    fix_result = fix_out[XLEN-1:0];
    if (mul_mode) begin
      if (op_q != OpMul) begin
        fix_result = fix_out[2*XLEN-1:XLEN];
      end
    end else if (div_by_zero) begin
      fix_result = op_q[1] ? a_q : {XLEN{1'b1}};
    end
  end

  // Control sequencing; Kill aborts any busy state and blocks a launch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StPrep;
      StPrep: state_d = Kill ? StIdle : StIter;
      StIter: begin
        if (Kill) begin
          state_d = StIdle;
        end else if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix:  state_d = Kill ? StIdle : StDone;
      StDone: state_d = accept ? StPrep : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture on launch, set up in PREP, step in ITER, commit in FIX.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d = muldiv_op_e'(Funct3);
      a_d  = SrcA;
      b_d  = SrcB;
    end
    unique case (state_q)
      StPrep: begin
        sign_a_d = neg_a;
        sign_b_d = neg_b;
        mag_d    = mul_mode ? abs_a : abs_b;
        acc_d    = {{XLEN{1'b0}}, (mul_mode ? abs_b : abs_a)};
        cnt_d    = '0;
      end
      StIter: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + CntW'(1);
      end
      StFix: begin
        if (!Kill) begin
          result_d = fix_result;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
  assign Done   = (state_q == StDone);
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at XLEN 8, 32 and 64 with a result scoreboard.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        kill;
  logic [2:0]  f3;
  logic [63:0] sa, sb;
  logic        start8, start32, start64;
  logic        busy8, done8, busy32, done32, busy64, done64;
  logic [7:0]  res8;
  logic [31:0] res32;
  logic [63:0] res64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] expv;
    int          w;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .Start(start8), .Kill(kill), .Funct3(f3),
    .SrcA(sa[7:0]), .SrcB(sb[7:0]), .Busy(busy8), .Done(done8), .Result(res8)
  );

  muldiv_iter #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .Start(start32), .Kill(kill), .Funct3(f3),
    .SrcA(sa[31:0]), .SrcB(sb[31:0]), .Busy(busy32), .Done(done32), .Result(res32)
  );

  muldiv_iter #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .Start(start64), .Kill(kill), .Funct3(f3),
    .SrcA(sa), .SrcB(sb), .Busy(busy64), .Done(done64), .Result(res64)
  );

  function automatic logic done_of(int w);
    case (w)
      8:       return done8;
      64:      return done64;
      default: return done32;
    endcase
  endfunction

  function automatic logic busy_of(int w);
    case (w)
      8:       return busy8;
      64:      return busy64;
      default: return busy32;
    endcase
  endfunction

  function automatic logic [63:0] res_of(int w);
    case (w)
      8:       return {56'd0, res8};
      64:      return res64;
      default: return {32'd0, res32};
    endcase
  endfunction

  // Arithmetic reference: sign/zero-extend to 130 bits and use native * / %.
  function automatic logic [63:0] ref_op(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [129:0]        lo_m, ax, bx, p, qu, ru;
    logic signed [129:0] qs, rs;
    logic [63:0]         am, bm;
    logic                sgn_a, sgn_b;
    lo_m  = (130'd1 << w) - 130'd1;
    am    = a & lo_m[63:0];
    bm    = b & lo_m[63:0];
    sgn_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    ax    = {66'd0, am};
    bx    = {66'd0, bm};
    if (sgn_a && am[w-1]) ax = ax | ~lo_m;
    if (sgn_b && bm[w-1]) bx = bx | ~lo_m;
    if (!op[2]) begin
      p = ax * bx;
      if (op == 3'b000) return 64'(p & lo_m);
      return 64'((p >> w) & lo_m);
    end
    if (bm == 64'd0) return op[1] ? am : lo_m[63:0];
    qs = $signed(ax) / $signed(bx);
    rs = $signed(ax) % $signed(bx);
    qu = qs;
    ru = rs;
    return op[1] ? 64'(ru & lo_m) : 64'(qu & lo_m);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    start8  = 1'b0;
    start32 = 1'b0;
    start64 = 1'b0;
  endtask

  task automatic launch(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                        logic [63:0] expv, string tag);
    exp_t e;
    e.expv = expv;
    e.w    = w;
    e.tag  = tag;
    sb_q.push_back(e);
    f3 = op;
    sa = a;
    sb = b;
    case (w)
      8:       start8 = 1'b1;
      64:      start64 = 1'b1;
      default: start32 = 1'b1;
    endcase
  endtask

  // Count edges until Done; inputs are scrambled after the accepting edge.
  task automatic wait_done(int w, output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    do begin
      tick();
      if (edges == 0) begin
        drop();
        f3 = ~f3;
        sa = ~sa;
        sb = sb ^ 64'h5A5A_A5A5_3C3C_C3C3;
      end
      edges++;
      if (busy_of(w)) busy_n++;
    end while (!done_of(w) && edges < w + 20);
  endtask

  task automatic check_pop(string tag);
    exp_t e;
    chk({tag, " sb depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({e.tag, " result"}, res_of(e.w), e.expv);
    end
  endtask

  task automatic run(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                     logic [63:0] expv, string tag);
    int edges, busy_n;
    launch(w, op, a, b, expv, tag);
    wait_done(w, edges, busy_n);
    chk({tag, " latency"}, 64'(edges - 1), 64'(w + 2));
    chk({tag, " busy"}, 64'(busy_n), 64'(w + 2));
    check_pop(tag);
  endtask

  task automatic run_model(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b, string tag);
    run(w, op, a, b, ref_op(w, op, a, b), tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int edges, busy_n, dones;
    logic [63:0] ra, rb;
    logic [2:0]  rop;

    reset = 1'b0;
    kill  = 1'b0;
    f3    = 3'd0;
    sa    = '0;
    sb    = '0;
    drop();
    tick();
    tick();
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset done", 64'(done32), 64'd0);
    chk("reset result", res_of(32), 64'd0);
    chk("reset result64", res_of(64), 64'd0);
    reset = 1'b1;
    tick();

    // XLEN=32 directed cases
    run(32, 3'b000, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul 7*-3");
    tick();
    chk("done pulse", 64'(done32), 64'd0);
    chk("result hold", res_of(32), 64'hFFFF_FFEB);
    run(32, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "mulh min*min");
    run(32, 3'b011, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "mulhu");
    run(32, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu");
    run(32, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "div -7/2");
    run(32, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "rem -7/2");
    run(32, 3'b101, 64'd100, 64'd7, 64'd14, "divu 100/7");
    run(32, 3'b111, 64'd100, 64'd7, 64'd2, "remu 100/7");
    run(32, 3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF, "divu by 0");
    run(32, 3'b110, 64'd5, 64'd0, 64'd5, "rem by 0");
    run(32, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div overflow");
    run(32, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "rem overflow");

    for (int i = 0; i < 6; i++) begin
      ra  = 64'($urandom());
      rb  = (i == 5) ? 64'($urandom_range(1, 9)) : 64'($urandom());
      rop = 3'($urandom_range(0, 7));
      run_model(32, rop, ra, rb, $sformatf("rand32 %0d op%0d", i, rop));
    end

    // Back-to-back: Start presented in the DONE cycle
    launch(32, 3'b101, 64'd1000, 64'd10, 64'd100, "b2b first");
    wait_done(32, edges, busy_n);
    check_pop("b2b first");
    launch(32, 3'b110, 64'hFFFF_FFF9, 64'd3, 64'hFFFF_FFFF, "b2b second");
    wait_done(32, edges, busy_n);
    chk("b2b spacing", 64'(edges), 64'd35);
    check_pop("b2b second");

    // Start pulse while busy must be ignored
    launch(32, 3'b101, 64'd100, 64'd7, 64'd14, "start ignored");
    tick();
    drop();
    edges = 1;
    repeat (4) begin
      tick();
      edges++;
    end
    f3      = 3'b000;
    sa      = 64'd5;
    sb      = 64'd5;
    start32 = 1'b1;
    tick();
    edges++;
    start32 = 1'b0;
    while (!done32 && edges < 60) begin
      tick();
      edges++;
    end
    chk("start ignored latency", 64'(edges - 1), 64'd34);
    check_pop("start ignored");
    tick();
    chk("no relaunch", 64'(busy32), 64'd0);

    // Kill on the 10th ITER cycle
    f3      = 3'b000;
    sa      = 64'd123;
    sb      = 64'd456;
    start32 = 1'b1;
    tick();
    drop();
    repeat (10) tick();
    chk("kill pre busy", 64'(busy32), 64'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill busy", 64'(busy32), 64'd0);
    chk("kill done", 64'(done32), 64'd0);
    dones = 0;
    repeat (40) begin
      tick();
      if (done32) dones++;
    end
    chk("kill no done", 64'(dones), 64'd0);
    chk("kill result kept", res_of(32), 64'd14);

    // Kill together with Start in IDLE blocks the launch
    start32 = 1'b1;
    kill    = 1'b1;
    tick();
    drop();
    kill = 1'b0;
    chk("kill beats start", 64'(busy32), 64'd0);
    run(32, 3'b000, 64'd123, 64'd456, 64'd56088, "after kill");

    // Asynchronous reset at ITER cycle 5
    f3      = 3'b000;
    sa      = 64'd1000;
    sb      = 64'd1000;
    start32 = 1'b1;
    tick();
    drop();
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("async rst busy", 64'(busy32), 64'd0);
    chk("async rst done", 64'(done32), 64'd0);
    chk("async rst result", res_of(32), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    run(32, 3'b000, 64'd3, 64'd4, 64'd12, "mul after reset");

    // XLEN=8
    run(8, 3'b000, 64'd7, 64'hFD, 64'hEB, "x8 mul");
    run(8, 3'b001, 64'h80, 64'h80, 64'h40, "x8 mulh");
    run(8, 3'b100, 64'hF9, 64'd2, 64'hFD, "x8 div");
    run(8, 3'b110, 64'hF9, 64'd2, 64'hFF, "x8 rem");
    run(8, 3'b101, 64'd5, 64'd0, 64'hFF, "x8 divu by 0");
    run(8, 3'b100, 64'h80, 64'hFF, 64'h80, "x8 div overflow");
    for (int i = 0; i < 4; i++) begin
      ra  = 64'($urandom_range(0, 255));
      rb  = 64'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      run_model(8, rop, ra, rb, $sformatf("rand8 %0d op%0d", i, rop));
    end

    // XLEN=64
    run(64, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "x64 mul");
    run(64, 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h4000_0000_0000_0000, "x64 mulh");
    run(64, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFE, "x64 mulhu");
    run(64, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, "x64 div overflow");
    run(64, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "x64 rem ovf");
    run(64, 3'b111, 64'd100, 64'd0, 64'd100, "x64 remu by 0");
    for (int i = 0; i < 4; i++) begin
      ra  = {32'($urandom()), 32'($urandom())};
      rb  = (i == 3) ? 64'($urandom_range(1, 1000)) : {32'($urandom()), 32'($urandom())};
      rop = 3'($urandom_range(0, 7));
      run_model(64, rop, ra, rb, $sformatf("rand64 %0d op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
